// File: rtl/tlm_fifo_pkg.sv
// Shared defaults and the sample payload type for the TLM FIFO.
package tlm_fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 65;
  localparam int unsigned DEFAULT_DEPTH = 8;

  typedef logic [64:0] sample_t;

endpackage

// File: rtl/tlm_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port. The data array is deliberately not reset.
module tlm_fifo_mem #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed word on an accepted put.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Asynchronous read gives first-word-fall-through at the head.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/tlm_fifo.sv
// Valid/ready FIFO with first-word-fall-through output. Pointers carry one
// extra wrap bit so full and empty are distinguished without a spare entry.
module tlm_fifo
  import tlm_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   put_valid,
  output logic                   put_ready,
  input  logic [WIDTH-1:0]       put_data,
  output logic                   get_valid,
  input  logic                   get_ready,
  output logic [WIDTH-1:0]       get_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        put_fire;
  logic        get_fire;

  // Flags, handshakes and next-state pointer/count arithmetic.
  always_comb begin
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty     = (wr_ptr_q == rd_ptr_q);
    put_ready = !full;
    get_valid = !empty;
    put_fire  = put_valid && put_ready;
    get_fire  = get_valid && get_ready;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (put_fire) begin
      wr_ptr_d = wr_ptr_q + ONE;
    end
    if (get_fire) begin
      rd_ptr_d = rd_ptr_q + ONE;
    end
    if (put_fire && !get_fire) begin
      count_d = count_q + ONE;
    end else if (get_fire && !put_fire) begin
      count_d = count_q - ONE;
    end
    count = count_q;
  end

  // Pointer and count registers; reset discards all stored entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  tlm_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (put_fire),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (put_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (get_data)
  );

endmodule

// File: tb/tb_tlm_fifo.sv
module tb_tlm_fifo;
  import tlm_fifo_pkg::*;

  localparam int unsigned W = 65;
  localparam int unsigned D = 8;

  logic                clk;
  logic                reset;
  logic                put_valid;
  logic                put_ready;
  logic [W-1:0]        put_data;
  logic                get_valid;
  logic                get_ready;
  logic [W-1:0]        get_data;
  logic [$clog2(D):0]  count;
  logic                full;
  logic                empty;

  int unsigned n_cmp;
  int unsigned n_fail;
  sample_t     model_q[$];

  tlm_fifo #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .put_valid (put_valid),
    .put_ready (put_ready),
    .put_data  (put_data),
    .get_valid (get_valid),
    .get_ready (get_ready),
    .get_data  (get_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Compare all observable state against the queue model.
  task automatic check_state(input string tag);
    int unsigned n;
    n = model_q.size();
    chk({tag, ".count"},     count,     n);
    chk({tag, ".empty"},     empty,     n == 0);
    chk({tag, ".full"},      full,      n == D);
    chk({tag, ".get_valid"}, get_valid, n != 0);
    chk({tag, ".put_ready"}, put_ready, n != D);
    if (n != 0) chk({tag, ".head"}, get_data, model_q[0]);
  endtask

  // One clock cycle of stimulus; called at posedge+1, returns at posedge+1.
  task automatic step(input string tag, input logic pv, input sample_t pd, input logic gr);
    bit put_ok, get_ok;
    put_valid = pv;
    put_data  = pd;
    get_ready = gr;
    put_ok = pv && (model_q.size() < D);
    get_ok = gr && (model_q.size() > 0);
    if (get_ok) chk({tag, ".pop"}, get_data, model_q[0]);
    @(posedge clk);
    #1;
    if (get_ok) void'(model_q.pop_front());
    if (put_ok) model_q.push_back(pd);
    check_state(tag);
  endtask

  function automatic sample_t rnd_sample();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[64:0];
  endfunction

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    reset     = 1'b0;
    put_valid = 1'b0;
    put_data  = '0;
    get_ready = 1'b0;

    // Reset held for 3 cycles, released between edges.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold.count", count, 0);
    chk("rst_hold.empty", empty, 1);
    chk("rst_hold.get_valid", get_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_state("reset");
    chk("reset.put_ready", put_ready, 1);
    chk("reset.full", full, 0);

    // Single transfer.
    step("single_put", 1'b1, 65'h1_0000_0000_DEAD_BEEF, 1'b0);
    chk("single.data", get_data, 65'h1_0000_0000_DEAD_BEEF);
    chk("single.valid", get_valid, 1);
    step("single_get", 1'b0, '0, 1'b1);
    chk("single.empty", empty, 1);

    // Fill to full, attempt overflow, then drain in order.
    for (int i = 0; i < 8; i++) step("fill", 1'b1, sample_t'(i), 1'b0);
    chk("fill.full", full, 1);
    chk("fill.put_ready", put_ready, 0);
    step("overflow", 1'b1, sample_t'(99), 1'b0);
    chk("overflow.count", count, 8);
    for (int i = 0; i < 8; i++) begin
      chk("drain.order", get_data, i);
      step("drain", 1'b0, '0, 1'b1);
    end
    chk("drain.empty", empty, 1);
    step("underflow", 1'b0, '0, 1'b1);

    // Streaming: put and get every cycle.
    for (int i = 0; i < 20; i++) begin
      step("stream", 1'b1, sample_t'(100 + i), 1'b1);
      chk("stream.count1", count, 1);
    end
    step("stream_tail", 1'b0, '0, 1'b1);

    // Wrap-around: three full fill/drain rounds with random payloads.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) step("wrap_fill", 1'b1, rnd_sample(), 1'b0);
      chk("wrap.full", full, 1);
      for (int i = 0; i < 8; i++) step("wrap_drain", 1'b0, '0, 1'b1);
      chk("wrap.empty", empty, 1);
    end

    // Mid-operation asynchronous reset.
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, rnd_sample(), 1'b0);
    put_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_q.delete();
    chk("midrst.count", count, 0);
    chk("midrst.empty", empty, 1);
    chk("midrst.get_valid", get_valid, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_state("post_rst");
    step("post_rst_put", 1'b1, 65'h0_1234_5678_9ABC_DEF0, 1'b0);
    chk("post_rst.data", get_data, 65'h0_1234_5678_9ABC_DEF0);
    step("post_rst_get", 1'b0, '0, 1'b1);

    // Random traffic against the queue model.
    for (int i = 0; i < 300; i++) begin
      step("random", 1'($urandom_range(0, 1)), rnd_sample(), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
